// File: rtl/charram_dram_ctrl.sv
// charram_dram_ctrl: sequencer and arbiter for one 16k x 4 character-RAM DRAM plane.
// Each 8-phase cycle holds a video slot (ph 0-3, always a pixel read) and a CPU
// slot (ph 4-7, a CPU read/write when one is pending, otherwise idle/refresh).
// Optional feature macro: CHARRAM_CTRL_REFRESH_EN turns the idle CPU slot into a
// RAS-only refresh driven by a row counter that wraps at REFRESH_ROWS-1.
//
// CPU handshake: i_CPU_REQ is a level held by the requester until o_CPU_ACK pulses
// for one i_MCLK; the request is sampled only on the i_CEN that enters ph4, and a
// request still high at the next ph4 is a new access.
module charram_dram_ctrl #(
  parameter int REFRESH_ROWS = 256
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CEN,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DATA,
  output logic        o_VID_VALID,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_ADDR,
  output logic [3:0]  o_DOUT,
  input  logic [3:0]  i_DIN,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n
);

  // What the CPU slot of the current cycle is doing.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_READ    = 2'd1,
    MODE_WRITE   = 2'd2,
    MODE_REFRESH = 2'd3
  } mode_e;

  logic [2:0]  ph_q, ph_d;
  logic [13:0] vid_addr_q, vid_addr_d;
  logic [13:0] cpu_addr_q, cpu_addr_d;
  logic [3:0]  cpu_din_q, cpu_din_d;
  mode_e       mode_q, mode_d;

  logic [7:0]  addr_q, addr_d;
  logic [3:0]  dout_q, dout_d;
  logic        ras_n_q, ras_n_d;
  logic        cas_n_q, cas_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [3:0]  vid_data_q, vid_data_d;
  logic        vid_valid_q, vid_valid_d;
  logic [3:0]  cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;

  // Access being sequenced in the phase about to be entered.
  logic [13:0] acc_addr;
  mode_e       acc_mode;
  logic [1:0]  k;

`ifdef CHARRAM_CTRL_REFRESH_EN
  localparam logic [7:0] REF_LAST = 8'(REFRESH_ROWS - 1);
  logic [7:0] ref_row_q, ref_row_d;
`else
  logic [7:0] unused_ref_rows;
  assign unused_ref_rows = 8'(REFRESH_ROWS - 1);
`endif

  // State and registered DRAM/CPU/video outputs; reset wins over i_CEN.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      ph_q        <= 3'd0;
      vid_addr_q  <= '0;
      cpu_addr_q  <= '0;
      cpu_din_q   <= '0;
      mode_q      <= MODE_IDLE;
      addr_q      <= '0;
      dout_q      <= '0;
      ras_n_q     <= 1'b1;
      cas_n_q     <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
`ifdef CHARRAM_CTRL_REFRESH_EN
      ref_row_q   <= '0;
`endif
    end else begin
      ph_q        <= ph_d;
      vid_addr_q  <= vid_addr_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_din_q   <= cpu_din_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      ras_n_q     <= ras_n_d;
      cas_n_q     <= cas_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
`ifdef CHARRAM_CTRL_REFRESH_EN
      ref_row_q   <= ref_row_d;
`endif
    end
  end

  // Phase sequencing: completions on leaving ph3/ph7, latches on entering ph0/ph4,
  // then the strobes and address for the phase being entered.
  always_comb begin
    ph_d        = ph_q;
    vid_addr_d  = vid_addr_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_din_d   = cpu_din_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    ras_n_d     = ras_n_q;
    cas_n_d     = cas_n_q;
    wr_n_d      = wr_n_q;
    rd_n_d      = rd_n_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = 1'b0;
    acc_addr    = '0;
    acc_mode    = MODE_IDLE;
    k           = 2'd0;
`ifdef CHARRAM_CTRL_REFRESH_EN
    ref_row_d   = ref_row_q;
`endif

    if (i_CEN) begin
      ph_d = ph_q + 3'd1;

      // Leaving ph3: the video read data is on i_DIN.
      if (ph_q == 3'd3) begin
        vid_data_d  = i_DIN;
        vid_valid_d = 1'b1;
      end

      // Leaving ph7: finish the CPU slot.
      if (ph_q == 3'd7) begin
        if (mode_q == MODE_READ) begin
          cpu_dout_d = i_DIN;
        end
        if (mode_q == MODE_READ || mode_q == MODE_WRITE) begin
          cpu_ack_d = 1'b1;
        end
`ifdef CHARRAM_CTRL_REFRESH_EN
        if (mode_q == MODE_REFRESH) begin
          ref_row_d = (ref_row_q == REF_LAST) ? 8'd0 : ref_row_q + 8'd1;
        end
`endif
      end

      // Entering ph0: the video slot fetches whatever address is presented now.
      if (ph_d == 3'd0) begin
        vid_addr_d = i_VID_ADDR;
      end

      // Entering ph4: arbitration; a later request waits a full cycle.
      if (ph_d == 3'd4) begin
        if (i_CPU_REQ) begin
          mode_d     = i_CPU_WR ? MODE_WRITE : MODE_READ;
          cpu_addr_d = i_CPU_ADDR;
          cpu_din_d  = i_CPU_DIN;
        end else begin
`ifdef CHARRAM_CTRL_REFRESH_EN
          mode_d = MODE_REFRESH;
`else
          mode_d = MODE_IDLE;
`endif
        end
      end

      k = ph_d[1:0];
      if (ph_d[2]) begin
        acc_addr = cpu_addr_d;
        acc_mode = mode_d;
      end else begin
        acc_addr = vid_addr_d;
        acc_mode = MODE_READ;
      end

      ras_n_d = 1'b1;
      cas_n_d = 1'b1;
      rd_n_d  = 1'b1;
      wr_n_d  = 1'b1;
      addr_d  = 8'd0;
      dout_d  = 4'd0;

      case (acc_mode)
        MODE_READ, MODE_WRITE: begin
          // Row during k=0..1, column (shifted into bits 6:1) during k=2..3.
          if (k[1]) begin
            addr_d  = {1'b0, acc_addr[13:8], 1'b0};
            cas_n_d = 1'b0;
            if (acc_mode == MODE_READ) begin
              rd_n_d = 1'b0;
            end else begin
              dout_d = cpu_din_d;
              wr_n_d = (k != 2'd3);
            end
          end else begin
            addr_d = acc_addr[7:0];
          end
          ras_n_d = (k == 2'd0);
        end
`ifdef CHARRAM_CTRL_REFRESH_EN
        MODE_REFRESH: begin
          addr_d  = ref_row_q;
          ras_n_d = (k == 2'd0);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_ADDR      = addr_q;
  assign o_DOUT      = dout_q;
  assign o_RAS_n     = ras_n_q;
  assign o_CAS_n     = cas_n_q;
  assign o_WR_n      = wr_n_q;
  assign o_RD_n      = rd_n_q;
  assign o_VID_DATA  = vid_data_q;
  assign o_VID_VALID = vid_valid_q;
  assign o_CPU_DOUT  = cpu_dout_q;
  assign o_CPU_ACK   = cpu_ack_q;

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Bench for charram_dram_ctrl: behavioural 4416 DRAM model, directed CPU access
// table, plus hand-written reset, video-fetch and refresh sequences.
module tb_charram_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [13:0] vid_addr;
  logic [3:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_wr;
  logic [13:0] cpu_addr;
  logic [3:0]  cpu_din;
  logic [3:0]  cpu_dout;
  logic        cpu_ack;
  logic [7:0]  addr;
  logic [3:0]  dout;
  logic [3:0]  din;
  logic        ras_n, cas_n, wr_n, rd_n;

  charram_dram_ctrl dut (
    .i_MCLK(clk), .i_RST(rst), .i_CEN(cen),
    .i_VID_ADDR(vid_addr), .o_VID_DATA(vid_data), .o_VID_VALID(vid_valid),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr),
    .i_CPU_DIN(cpu_din), .o_CPU_DOUT(cpu_dout), .o_CPU_ACK(cpu_ack),
    .o_ADDR(addr), .o_DOUT(dout), .i_DIN(din),
    .o_RAS_n(ras_n), .o_CAS_n(cas_n), .o_WR_n(wr_n), .o_RD_n(rd_n)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DRAM model ----------------
  logic [3:0]  mem [16384];
  logic [7:0]  row_l = 8'd0;
  logic [5:0]  col_l = 6'd0;
  logic        prev_ras = 1'b1;
  logic        prev_cas = 1'b1;
  logic [13:0] pre_addr = 14'd0;
  logic [3:0]  pre_data = 4'd0;
  logic        pre_go = 1'b0;
  logic        pre_seen = 1'b0;

  always @(negedge clk) begin
    if (pre_go != pre_seen) begin
      mem[pre_addr] = pre_data;
      pre_seen = pre_go;
    end
    if (prev_ras && !ras_n) row_l = addr;
    if (prev_cas && !cas_n) col_l = addr[6:1];
    if (!wr_n) mem[{col_l, row_l}] = dout;
    prev_ras = ras_n;
    prev_cas = cas_n;
  end

  assign din = rd_n ? 4'h0 : mem[{col_l, row_l}];

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_q[$];
  logic [2:0]  tb_ph = 3'd0;
  int          cyc = 0;
  int          last_vld = -1;
  int          vld_cnt = 0;
  int          ack_cnt = 0;
  logic [7:0]  wr_mask = 8'd0;
  logic [7:0]  rd_mask = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    cyc++;
    cen = 1'b0;
    if (c && !rst) begin
      tb_ph = tb_ph + 3'd1;
      if (!wr_n) wr_mask[tb_ph] = 1'b1;
      if (!rd_n) rd_mask[tb_ph] = 1'b1;
    end
    if (vid_valid) begin
      vld_cnt++;
      if (last_vld >= 0) check("vid_valid_spacing", cyc - last_vld, 32);
      last_vld = cyc;
    end
    if (cpu_ack) ack_cnt++;
  endtask

  task automatic phase();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] a;
    logic [3:0]  d;
    logic [3:0]  exp;
    int          s;
  } vec_t;

  // One CPU access, request raised while the controller sits in phase v.s.
  task automatic run_vec(input vec_t v);
    int         lat;
    int         exp_lat;
    int         ack0;
    logic       got;
    logic [3:0] e;
    for (int i = 0; i < 8 && tb_ph != 3'(v.s); i++) phase();
    wr_mask  = 8'd0;
    rd_mask  = 8'd0;
    cpu_req  = 1'b1;
    cpu_wr   = v.wr;
    cpu_addr = v.a;
    cpu_din  = v.d;
    if (!v.wr) exp_q.push_back(v.exp);
    exp_lat = (v.s < 4) ? 8 - v.s : 16 - v.s;
    ack0 = ack_cnt;
    got  = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 24; n++) begin
      phase();
      if (cpu_ack) begin
        got = 1'b1;
        lat = n;
        break;
      end
    end
    cpu_req = 1'b0;
    check("ack_seen", got, 1);
    if (got) begin
      check("ack_latency", lat, exp_lat);
      check("ack_after_ph7", tb_ph, 0);
      if (v.wr) begin
        check("wr_strobe_phases", wr_mask, 8'h80);
        check("no_rd_in_cpu_write", rd_mask[7:4], 0);
      end else begin
        e = exp_q.pop_front();
        check("cpu_read_data", cpu_dout, e);
        check("rd_strobe_phases", rd_mask[7:4], 4'b1100);
        check("no_wr_in_cpu_read", wr_mask, 0);
      end
    end else if (!v.wr) begin
      e = exp_q.pop_front();
    end
    phase();
    check("ack_pulse_count", ack_cnt - ack0, 1);
  endtask

  vec_t vecs[8];

  initial begin
`ifdef CHARRAM_CTRL_REFRESH_EN
    int idle_cyc = 258;
`else
    int idle_cyc = 4;
`endif
    int ack0;
    int n_edges;
    logic got;

    vecs[0] = '{wr: 1'b1, a: 14'h0123, d: 4'hC, exp: 4'h0, s: 0};
    vecs[1] = '{wr: 1'b0, a: 14'h0123, d: 4'h0, exp: 4'hC, s: 2};
    vecs[2] = '{wr: 1'b1, a: 14'h3FFF, d: 4'h5, exp: 4'h0, s: 3};
    vecs[3] = '{wr: 1'b1, a: 14'h0000, d: 4'hA, exp: 4'h0, s: 5};
    vecs[4] = '{wr: 1'b0, a: 14'h3FFF, d: 4'h0, exp: 4'h5, s: 4};
    vecs[5] = '{wr: 1'b0, a: 14'h0000, d: 4'h0, exp: 4'hA, s: 7};
    vecs[6] = '{wr: 1'b1, a: 14'h2A5C, d: 4'h3, exp: 4'h0, s: 1};
    vecs[7] = '{wr: 1'b0, a: 14'h2A5C, d: 4'h0, exp: 4'h3, s: 6};

    // ---- reset ----
    rst = 1'b1; cen = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 14'd0; cpu_din = 4'd0; vid_addr = 14'd0;
    repeat (3) tick(1'b0);
    check("rst_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    rst = 1'b0;
    tb_ph = 3'd0;

    // ---- idle cycles: video every 8 phases, CPU slot idle or refreshing ----
    vld_cnt = 0;
    ack_cnt = 0;
    for (int c = 0; c < idle_cyc; c++) begin
      for (int p = 0; p < 8; p++) begin
        phase();
        if (tb_ph == 3'd5) begin
`ifdef CHARRAM_CTRL_REFRESH_EN
          check("refresh_row", addr, c % 256);
          check("refresh_ras", ras_n, 0);
          check("refresh_cas", cas_n, 1);
`else
          check("idle_ras", ras_n, 1);
          check("idle_addr", addr, 0);
`endif
        end
      end
    end
    check("idle_vid_valid_count", vld_cnt, idle_cyc);
    check("idle_no_ack", ack_cnt, 0);

    // ---- video fetch of 14'h2A5C ----
    vid_addr = 14'h2A5C;
    pre_addr = 14'h2A5C;
    pre_data = 4'h9;
    pre_go   = ~pre_go;
    for (int i = 0; i < 8; i++) begin
      phase();
      if (tb_ph == 3'd0) break;
    end
    check("vid_ph0_row", addr, 8'h5C);
    check("vid_ph0_ras", ras_n, 1);
    phase();
    check("vid_ph1_row", addr, 8'h5C);
    check("vid_ph1_strobes", {ras_n, cas_n}, 2'b01);
    phase();
    check("vid_ph2_col", addr, 8'h54);
    check("vid_ph2_strobes", {ras_n, cas_n, rd_n, wr_n}, 4'b0001);
    phase();
    check("vid_ph3_strobes", {ras_n, cas_n, rd_n, wr_n}, 4'b0001);
    phase();
    check("vid_data", vid_data, 4'h9);
    check("vid_valid_pulse", vid_valid, 1);

    // ---- CPU access table ----
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // ---- reset during ph6 of a CPU write, then re-issue ----
    for (int i = 0; i < 8 && tb_ph != 3'd2; i++) phase();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0456; cpu_din = 4'h7;
    for (int i = 0; i < 8 && tb_ph != 3'd6; i++) phase();
    check("pre_rst_cas_low", cas_n, 0);
    ack0 = ack_cnt;
    rst = 1'b1;
    last_vld = -1;
    tick(1'b0);
    check("midrst_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
    check("midrst_addr", addr, 0);
    tick(1'b1);
    tick(1'b0);
    rst = 1'b0;
    tb_ph = 3'd0;
    got = 1'b0;
    n_edges = 0;
    for (int n = 1; n <= 24; n++) begin
      phase();
      if (cpu_ack) begin
        got = 1'b1;
        n_edges = n;
        break;
      end
    end
    cpu_req = 1'b0;
    check("reissue_ack_seen", got, 1);
    check("reissue_latency_from_ph0", n_edges, 8);
    check("no_ack_from_aborted", ack_cnt - ack0, 1);
    run_vec('{wr: 1'b0, a: 14'h0456, d: 4'h0, exp: 4'h7, s: 1});
    run_vec('{wr: 1'b0, a: 14'h0123, d: 4'h0, exp: 4'hC, s: 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
